// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU event counter bank: default sizes and the
// measurement window state encoding.
package pmu_pkg;

    localparam int unsigned REG_WIDTH  = 32;
    localparam int unsigned N_COUNTERS = 9;
    localparam int unsigned IDX_W      = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;

    typedef enum logic {
        StIdle,
        StRun
    } win_state_e;

endpackage

// File: rtl/pmu_counter_slice.sv
// One event counter with its sticky overflow flag and window snapshot register.
// Priority: reset, soft reset, software write, window end, increment.
module pmu_counter_slice #(
    parameter int unsigned REG_WIDTH = pmu_pkg::REG_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_softrst,
    input  logic                 i_inc,
    input  logic                 i_we,
    input  logic [REG_WIDTH-1:0] i_wr_data,
    input  logic                 i_win_end,
    input  logic                 i_ovf_clr,
    output logic [REG_WIDTH-1:0] o_count,
    output logic [REG_WIDTH-1:0] o_snapshot,
    output logic                 o_overflow
);
    import pmu_pkg::*;

    logic [REG_WIDTH-1:0] r_cnt;
    logic [REG_WIDTH-1:0] r_snap;
    logic                 r_ovf;
    logic [REG_WIDTH-1:0] w_cnt_inc;
    logic                 w_wrap;

    assign w_cnt_inc = r_cnt + REG_WIDTH'(i_inc);
    // A write drops this cycle's event, so it can never cause a wrap.
    assign w_wrap    = i_inc && !i_we && (r_cnt == '1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_snap <= '0;
            r_ovf  <= 1'b0;
        end else if (i_softrst) begin
            r_cnt  <= '0;
            r_snap <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_we) begin
                r_cnt <= i_wr_data;
            end else if (i_win_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
            if (i_win_end) begin
                r_snap <= i_we ? r_cnt : w_cnt_inc;
            end
            r_ovf <= w_wrap | (r_ovf & ~i_ovf_clr);
        end
    end

    assign o_count    = r_cnt;
    assign o_snapshot = r_snap;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/pmu_event_counters.sv
// Bank of event counters with software writes, sticky overflow flags, a masked
// overflow interrupt and a periodic measurement window that snapshots and clears.
module pmu_event_counters #(
    parameter int unsigned REG_WIDTH  = pmu_pkg::REG_WIDTH,
    parameter int unsigned N_COUNTERS = pmu_pkg::N_COUNTERS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  softrst_i,
    input  logic                  en_i,
    input  logic [N_COUNTERS-1:0] events_i,
    input  logic                  we_i,
    input  logic [((N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1)-1:0] wr_idx_i,
    input  logic [REG_WIDTH-1:0]  wr_data_i,
    input  logic [REG_WIDTH-1:0]  window_period_i,
    input  logic [N_COUNTERS-1:0] overflow_mask_i,
    input  logic [N_COUNTERS-1:0] overflow_clr_i,
    output logic [REG_WIDTH-1:0]  counter_value_o [0:N_COUNTERS-1],
    output logic [REG_WIDTH-1:0]  snapshot_o [0:N_COUNTERS-1],
    output logic                  snapshot_valid_o,
    output logic [N_COUNTERS-1:0] overflow_o,
    output logic                  intr_overflow_o
);
    import pmu_pkg::*;

    localparam int unsigned WIDX = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;

    win_state_e            r_state;
    win_state_e            w_state_d;
    logic [REG_WIDTH-1:0]  r_win_cnt;
    logic [REG_WIDTH-1:0]  w_win_cnt_d;
    logic                  r_snap_valid;
    logic                  w_active;
    logic                  w_win_end;
    logic [N_COUNTERS-1:0] w_ovf;

    assign w_active = en_i && (window_period_i != '0);

    always_comb begin
        w_state_d   = r_state;
        w_win_cnt_d = r_win_cnt;
        w_win_end   = 1'b0;
        if (softrst_i) begin
            w_state_d   = StIdle;
            w_win_cnt_d = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_win_cnt_d = '0;
                    if (w_active) begin
                        // The entering cycle already counts as the first window cycle.
                        w_state_d = StRun;
                        if (window_period_i == REG_WIDTH'(1)) begin
                            w_win_end = 1'b1;
                        end else begin
                            w_win_cnt_d = REG_WIDTH'(1);
                        end
                    end
                end
                StRun: begin
                    if (!w_active) begin
                        w_state_d   = StIdle;
                        w_win_cnt_d = '0;
                    end else if (r_win_cnt >= window_period_i - REG_WIDTH'(1)) begin
                        w_win_end   = 1'b1;
                        w_win_cnt_d = '0;
                    end else begin
                        w_win_cnt_d = r_win_cnt + REG_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_d   = StIdle;
                    w_win_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_win_cnt    <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_win_cnt    <= w_win_cnt_d;
            r_snap_valid <= w_win_end;
        end
    end

    for (genvar g = 0; g < N_COUNTERS; g++) begin : g_slice
        pmu_counter_slice #(
            .REG_WIDTH(REG_WIDTH)
        ) u_slice (
            .i_clk      (clk_i),
            .i_rst      (rst_i),
            .i_softrst  (softrst_i),
            .i_inc      (en_i && events_i[g]),
            .i_we       (we_i && (wr_idx_i == WIDX'(g))),
            .i_wr_data  (wr_data_i),
            .i_win_end  (w_win_end),
            .i_ovf_clr  (overflow_clr_i[g]),
            .o_count    (counter_value_o[g]),
            .o_snapshot (snapshot_o[g]),
            .o_overflow (w_ovf[g])
        );
    end

    assign snapshot_valid_o = r_snap_valid;
    assign overflow_o       = w_ovf;
    assign intr_overflow_o  = |(w_ovf & overflow_mask_i);

endmodule

// File: tb/tb_pmu_event_counters.sv
// Self-checking bench for pmu_event_counters: directed vector table, hand-written
// window/reset sequences and randomized traffic against a behavioural model.
module tb_pmu_event_counters;

    localparam int N = 9;
    localparam int W = 32;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          softrst;
    logic          en;
    logic [N-1:0]  events;
    logic          we;
    logic [3:0]    wr_idx;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  period;
    logic [N-1:0]  mask;
    logic [N-1:0]  clr;
    logic [W-1:0]  cval [0:N-1];
    logic [W-1:0]  snap [0:N-1];
    logic          snap_valid;
    logic [N-1:0]  ovf;
    logic          intr;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    longint unsigned m_cnt  [N];
    longint unsigned m_snap [N];
    logic [N-1:0]    m_ovf;
    longint unsigned m_win;   // enabled cycles already elapsed in the current window
    bit              m_valid;

    pmu_event_counters #(
        .REG_WIDTH (W),
        .N_COUNTERS(N)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .softrst_i       (softrst),
        .en_i            (en),
        .events_i        (events),
        .we_i            (we),
        .wr_idx_i        (wr_idx),
        .wr_data_i       (wr_data),
        .window_period_i (period),
        .overflow_mask_i (mask),
        .overflow_clr_i  (clr),
        .counter_value_o (cval),
        .snapshot_o      (snap),
        .snapshot_valid_o(snap_valid),
        .overflow_o      (ovf),
        .intr_overflow_o (intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned got,
                       input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        m_ovf   = '0;
        m_win   = 0;
        m_valid = 0;
    endtask

    task automatic model_step();
        bit              active;
        bit              wend;
        bit              wr;
        longint unsigned nxt;
        if (softrst) begin
            model_reset();
            return;
        end
        active = en && (period != 0);
        wend   = active && (m_win + 1 >= longint'(period));
        for (int i = 0; i < N; i++) begin
            wr  = we && (int'(wr_idx) == i);
            nxt = m_cnt[i] + ((en && events[i]) ? 1 : 0);
            if (wend) m_snap[i] = wr ? m_cnt[i] : nxt % MOD;
            if (!wr && nxt == MOD) m_ovf[i] = 1'b1;
            else if (clr[i]) m_ovf[i] = 1'b0;
            if (wr) m_cnt[i] = wr_data;
            else if (wend) m_cnt[i] = 0;
            else m_cnt[i] = nxt % MOD;
        end
        m_win   = (!active || wend) ? 0 : m_win + 1;
        m_valid = wend;
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("cnt[%0d]", i), cval[i], m_cnt[i]);
            chk($sformatf("snap[%0d]", i), snap[i], m_snap[i]);
        end
        chk("overflow", ovf, m_ovf);
        chk("snap_valid", snap_valid, m_valid);
        chk("intr", intr, |(m_ovf & mask));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        softrst = 0; en = 0; events = '0; we = 0; wr_idx = '0; wr_data = '0;
        clr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        bit           en;
        logic [N-1:0] ev;
        bit           we;
        logic [3:0]   idx;
        logic [W-1:0] data;
        logic [N-1:0] mask;
        logic [N-1:0] clr;
        int           ci;
        logic [W-1:0] exp_cnt;
        logic [N-1:0] exp_ovf;
        bit           exp_intr;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // Counter 0 counts five events, wrap of counter 2, dropped events on write,
        // out-of-range write, set-wins-over-clear on counter 4, en low freezing.
        for (int k = 0; k < 5; k++)
            vecs[k] = '{1, 9'h001, 0, 0, 0, 9'h000, 9'h000, 0, W'(k + 1), 9'h000, 0};
        vecs[5]  = '{1, 9'h004, 1, 2, 32'hFFFF_FFFE, 9'h004, 9'h000, 2, 32'hFFFF_FFFE, 9'h000, 0};
        vecs[6]  = '{1, 9'h004, 0, 0, 0, 9'h004, 9'h000, 2, 32'hFFFF_FFFF, 9'h000, 0};
        vecs[7]  = '{1, 9'h004, 0, 0, 0, 9'h004, 9'h000, 2, 32'h0, 9'h004, 1};
        vecs[8]  = '{1, 9'h000, 0, 0, 0, 9'h000, 9'h000, 2, 32'h0, 9'h004, 0};
        vecs[9]  = '{1, 9'h000, 0, 0, 0, 9'h004, 9'h004, 2, 32'h0, 9'h000, 0};
        vecs[10] = '{1, 9'h008, 1, 3, 32'h100, 9'h000, 9'h000, 3, 32'h100, 9'h000, 0};
        vecs[11] = '{1, 9'h008, 0, 0, 0, 9'h000, 9'h000, 3, 32'h101, 9'h000, 0};
        vecs[12] = '{1, 9'h000, 1, 12, 32'h5, 9'h000, 9'h000, 3, 32'h101, 9'h000, 0};
        vecs[13] = '{1, 9'h000, 1, 4, 32'hFFFF_FFFF, 9'h010, 9'h000, 4, 32'hFFFF_FFFF, 9'h000, 0};
        vecs[14] = '{1, 9'h010, 0, 0, 0, 9'h010, 9'h010, 4, 32'h0, 9'h010, 1};
        vecs[15] = '{0, 9'h010, 0, 0, 0, 9'h010, 9'h000, 4, 32'h0, 9'h010, 1};
        vecs[16] = '{1, 9'h000, 0, 0, 0, 9'h010, 9'h010, 4, 32'h0, 9'h000, 0};

        set_idle();
        period = '0;
        mask   = '0;
        do_reset();

        for (int k = 0; k < 17; k++) begin
            en = vecs[k].en; events = vecs[k].ev; we = vecs[k].we; wr_idx = vecs[k].idx;
            wr_data = vecs[k].data; mask = vecs[k].mask; clr = vecs[k].clr;
            step();
            chk($sformatf("tbl%0d_cnt", k), cval[vecs[k].ci], vecs[k].exp_cnt);
            chk($sformatf("tbl%0d_ovf", k), ovf, vecs[k].exp_ovf);
            chk($sformatf("tbl%0d_intr", k), intr, vecs[k].exp_intr);
        end

        // Window of 4 with a constant event on counter 1
        set_idle();
        mask = '0;
        do_reset();
        period = 4; en = 1; events = 9'h002;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("win4_valid", snap_valid, (k % 4) == 0);
            if (k % 4 == 0) begin
                chk("win4_snap", snap[1], 4);
                chk("win4_cnt_clear", cval[1], 0);
            end else begin
                chk("win4_cnt", cval[1], k % 4);
            end
        end

        // Period 1 ends the window every enabled cycle
        period = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("win1_valid", snap_valid, 1);
            chk("win1_snap", snap[1], 1);
            chk("win1_cnt", cval[1], 0);
        end

        // Shrinking the period mid-window ends it immediately
        period = 8;
        repeat (3) step();
        chk("shrink_pre", cval[1], 3);
        period = 3;
        step();
        chk("shrink_valid", snap_valid, 1);
        chk("shrink_snap", snap[1], 4);

        // Soft reset mid-window with an overflow flag set
        events = '0; we = 1; wr_idx = 0; wr_data = 32'hFFFF_FFFF;
        step();
        we = 0; events = 9'h003; mask = 9'h001;
        step();
        chk("pre_soft_ovf", ovf[0], 1);
        softrst = 1;
        step();
        for (int i = 0; i < N; i++) begin
            chk("soft_cnt", cval[i], 0);
            chk("soft_snap", snap[i], 0);
        end
        chk("soft_ovf", ovf, 0);
        chk("soft_intr", intr, 0);
        softrst = 0; period = 4; events = 9'h002;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("soft_restart_valid", snap_valid, k == 4);
        end

        // Asynchronous reset in the middle of counting
        events = 9'h1FF; mask = '1;
        repeat (3) step();
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) chk("arst_cnt", cval[i], 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_valid", snap_valid, 0);
        chk("arst_intr", intr, 0);
        model_reset();
        #2;
        rst = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            softrst = ($urandom_range(0, 63) == 0);
            en      = ($urandom_range(0, 7) != 0);
            events  = N'($urandom);
            we      = ($urandom_range(0, 5) == 0);
            wr_idx  = 4'($urandom_range(0, 15));
            wr_data = ($urandom_range(0, 1) == 0) ? $urandom
                                                  : 32'hFFFF_FFFF - $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) period = $urandom_range(0, 6);
            mask    = N'($urandom);
            clr     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmu_event_counters.md
# pmu_event_counters

Bank of N_COUNTERS free-running event counters that is the direct producer of the per-counter values consumed by the PMU quota checker. Each counter increments on its single-bit event input. Counters are software-writable, wrap with sticky overflow flags and a masked overflow interrupt, and support an optional periodic measurement window that snapshots and clears all counters. Sits between the event-routing crossbar and the quota/overflow consumers in the PMU wrapper.

## Interface
- REG_WIDTH, 32, width of each counter, snapshot and window registers
- N_COUNTERS, 9, number of counters; legal range 1..64
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- softrst_i  in  1  synchronous soft reset from configuration registers, active high
- en_i  in  1  global count enable
- events_i  in  N_COUNTERS  one event pulse per counter per cycle
- we_i  in  1  counter write strobe
- wr_idx_i  in  $clog2(N_COUNTERS) (min 1)  counter selected by we_i
- wr_data_i  in  REG_WIDTH  value loaded on write
- window_period_i  in  REG_WIDTH  window length in cycles; 0 disables windowing
- overflow_mask_i  in  N_COUNTERS  overflow bits allowed to raise the interrupt
- overflow_clr_i  in  N_COUNTERS  per-bit clear of sticky overflow flags
- counter_value_o  out  REG_WIDTH x N_COUNTERS  live counter values (unpacked array [0:N_COUNTERS-1])
- snapshot_o  out  REG_WIDTH x N_COUNTERS  values captured at last window end
- snapshot_valid_o  out  1  one-cycle pulse when snapshot_o updates
- overflow_o  out  N_COUNTERS  sticky wrap flags
- intr_overflow_o  out  1  |(overflow_o & overflow_mask_i)

## Operation
- Per-counter priority, highest first: rst_i, softrst_i, write (we_i and wr_idx_i==i), window end, increment.
- Increment: en_i && events_i[i] -> counter+1 modulo 2^REG_WIDTH. At all-ones, wraps to 0 and sets overflow_o[i].
- Write: counter[i] <= wr_data_i; that cycle's event on counter i is dropped; overflow flag untouched. wr_idx_i >= N_COUNTERS: write ignored.
- Window FSM, states IDLE / RUN:
  - IDLE: window_period_i==0 or en_i low; window counter held at 0.
  - IDLE -> RUN when window_period_i!=0 and en_i high.
  - RUN: window counter increments each enabled cycle.
  - Window end: count reaches window_period_i-1. snapshot_o[i] <= counter[i] + (en_i&&events_i[i]), full-width wrap. counter[i] <= 0. snapshot_valid_o pulses. Window counter <= 0.
  - A wrap at window end still sets overflow.
  - RUN -> IDLE when window_period_i becomes 0 or en_i drops; window counter cleared. en_i low freezes counters.
  - window_period_i changed mid-window: the new value is compared immediately; if count >= new period-1, window end fires that cycle.
- A write to counter i coinciding with window end: counter gets wr_data_i; snapshot[i] still captured from the pre-write value.
- Overflow flag: set-wins over overflow_clr_i in the same cycle. Cleared by softrst_i.
- softrst_i clears counters, snapshots, flags and the window FSM. Configuration inputs are unaffected.

## Timing
- Reset values: all counter_value_o, snapshot_o, overflow_o = 0; snapshot_valid_o=0; intr_overflow_o=0; FSM in IDLE.
- Event at cycle t is visible on counter_value_o at t+1.
- Overflow flag and intr_overflow_o assert at t+1 after the wrapping event.
- Interrupt is combinational from the flag register and the mask input. Mask changes take effect the same cycle.
- Window of period P: snapshot_valid_o pulses every P enabled cycles. P=1 pulses every enabled cycle.
- All outputs registered except intr_overflow_o.

## Structure
- Shared package pmu_pkg holds:
  - default REG_WIDTH and N_COUNTERS
  - IDX_W = max(1, $clog2(N_COUNTERS))
  - window FSM enum (IDLE, RUN)
- Sub-module pmu_counter_slice: one counter, its overflow flag and snapshot register, with the priority logic. Instantiated N_COUNTERS times in a generate loop.
- Window FSM and interrupt OR live in the top level.

## Test plan
- Reset then en_i=1, events_i[0] high 5 cycles -> counter_value_o[0]=5, all others 0, intr_overflow_o=0.
- Write 32'hFFFF_FFFE to counter 2, two events, mask[2]=1 -> counter wraps to 0, overflow_o[2]=1, intr_overflow_o=1 next cycle. overflow_clr_i[2] -> both deassert.
- window_period_i=4, events_i[1] constant -> snapshot_valid_o every 4 cycles, snapshot_o[1]=4, counter restarts from 0.
- Write to counter 3 and event on counter 3 in the same cycle with we_i for idx 3 -> value equals wr_data_i, event dropped.
- softrst_i mid-window with overflow set -> all counters, snapshots and flags 0, FSM restarts on next enabled cycle.
- rst_i asserted asynchronously mid-count -> outputs 0 before the next clock edge.
